// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if: resolved key event bus from the PS/2 decoder to the key-to-note converter
interface ps2_scan_decoder_if;
  logic [7:0] keyboard_code;
  logic makeBreak;
  logic extended;
  logic code_valid;
  logic frame_err;
  modport master(output keyboard_code, makeBreak, extended, code_valid, frame_err);
  modport slave(input keyboard_code, makeBreak, extended, code_valid, frame_err);
endinterface

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: PS/2 frame deserializer with F0/E0 prefix resolution into single key events
module ps2_scan_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clock,
  input logic reset,
  input logic ps2_clk,
  input logic ps2_dat,
  ps2_scan_decoder_if.master bus
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic c1, c2, d1, d2, filt, filt_q, fe, par, bp, ep, ok;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [1:0] state;
  logic [7:0] sh;
  logic [2:0] bcnt;
  assign fe = filt_q & ~filt;
  assign ok = d2 & (^{sh, par});
  always_ff @(posedge clock) begin
    if (reset) begin
      {c1, c2, d1, d2, filt, filt_q} <= '1;
      fcnt <= '0;
    end else begin
      c1 <= ps2_clk;
      c2 <= c1;
      d1 <= ps2_dat;
      d2 <= d1;
      filt_q <= filt;
      if (c2 == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= c2;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sh <= '0;
      bcnt <= '0;
      par <= 1'b0;
      tcnt <= '0;
      bp <= 1'b0;
      ep <= 1'b0;
      bus.keyboard_code <= 8'h00;
      bus.makeBreak <= 1'b0;
      bus.extended <= 1'b0;
      bus.code_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.code_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
        state <= IDLE;
        tcnt <= '0;
        bus.frame_err <= 1'b1;
        bp <= 1'b0;
        ep <= 1'b0;
      end else begin
        tcnt <= (state == IDLE || fe) ? '0 : tcnt + 1'b1;
        if (fe) begin
          case (state)
            IDLE: begin
              state <= d2 ? IDLE : DATA;
              bcnt <= '0;
            end
            DATA: begin
              sh <= {d2, sh[7:1]};
              bcnt <= bcnt + 1'b1;
              state <= (bcnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
              par <= d2;
              state <= STOP;
            end
            default: begin
              state <= IDLE;
              // prefixes only arm flags; any other byte emits the event and consumes them
              if (!ok) begin
                bus.frame_err <= 1'b1;
                bp <= 1'b0;
                ep <= 1'b0;
              end else if (sh == 8'hF0) bp <= 1'b1;
              else if (sh == 8'hE0) ep <= 1'b1;
              else begin
                bus.keyboard_code <= sh;
                bus.makeBreak <= ~bp;
                bus.extended <= ep;
                bus.code_valid <= 1'b1;
                bp <= 1'b0;
                ep <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed PS/2 frame stimulus with immediate-assertion checks
module tb_ps2_scan_decoder;
  localparam int H = 20;
  localparam int TO = 1000;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  int errors = 0, checks = 0, ncv = 0, nfe = 0, cv0, fe0;
  ps2_scan_decoder_if bus_if ();
  ps2_scan_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .bus(bus_if.master)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    ncv <= ncv + int'(bus_if.code_valid);
    nfe <= nfe + int'(bus_if.frame_err);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, input logic glitch);
    @(negedge clk);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(6);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(H - 9);
    end else wait_cyc(H);
    ps2_clk = 1'b0;
    if (glitch) begin
      wait_cyc(10);
      ps2_clk = 1'b1;
      wait_cyc(3);
      ps2_clk = 1'b0;
      wait_cyc(H - 13);
    end else wait_cyc(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(~^b ^ bad_par, glitch);
    send_bit(~bad_stop, glitch);
    ps2_dat = 1'b1;
    wait_cyc(2 * H);
  endtask
  task automatic mark();
    cv0 = ncv;
    fe0 = nfe;
  endtask
  initial begin
    wait_cyc(5);
    chk("rst_code", 32'(bus_if.keyboard_code), 32'h00);
    chk("rst_mb", 32'(bus_if.makeBreak), 0);
    chk("rst_ext", 32'(bus_if.extended), 0);
    chk("rst_cv", 32'(bus_if.code_valid), 0);
    chk("rst_fe", 32'(bus_if.frame_err), 0);
    rst = 1'b0;
    wait_cyc(5);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    mark();
    send_frame(8'h1C, 0, 0, 0);
    chk("t1_fe", 32'(nfe - fe0), 0);
    chk("t1_cv", 32'(ncv - cv0), 1);
    chk("t1_code", 32'(bus_if.keyboard_code), 32'h1C);
    chk("t1_mb", 32'(bus_if.makeBreak), 1);
    chk("t1_ext", 32'(bus_if.extended), 0);
    mark();
    send_frame(8'hF0, 0, 0, 0);
    chk("t2_f0_cv", 32'(ncv - cv0), 0);
    send_frame(8'h1C, 0, 0, 0);
    chk("t2_cv", 32'(ncv - cv0), 1);
    chk("t2_code", 32'(bus_if.keyboard_code), 32'h1C);
    chk("t2_mb", 32'(bus_if.makeBreak), 0);
    mark();
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    chk("t3_cv", 32'(ncv - cv0), 1);
    chk("t3_code", 32'(bus_if.keyboard_code), 32'h5A);
    chk("t3_mb", 32'(bus_if.makeBreak), 0);
    chk("t3_ext", 32'(bus_if.extended), 1);
    send_frame(8'h29, 0, 0, 0);
    chk("t3b_code", 32'(bus_if.keyboard_code), 32'h29);
    chk("t3b_mb", 32'(bus_if.makeBreak), 1);
    chk("t3b_ext", 32'(bus_if.extended), 0);
    mark();
    send_frame(8'h23, 1, 0, 0);
    chk("t4_par_fe", 32'(nfe - fe0), 1);
    chk("t4_par_cv", 32'(ncv - cv0), 0);
    chk("t4_par_code", 32'(bus_if.keyboard_code), 32'h29);
    mark();
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h11, 0, 1, 0);
    chk("t4_stop_fe", 32'(nfe - fe0), 1);
    send_frame(8'h24, 0, 0, 0);
    chk("t4_cv", 32'(ncv - cv0), 1);
    chk("t4_code", 32'(bus_if.keyboard_code), 32'h24);
    chk("t4_mb", 32'(bus_if.makeBreak), 1);
    mark();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    wait_cyc(TO + 10);
    chk("t5_fe", 32'(nfe - fe0), 1);
    chk("t5_idle", 32'(dut.state), 0);
    send_frame(8'h16, 0, 0, 0);
    chk("t5_code", 32'(bus_if.keyboard_code), 32'h16);
    chk("t5_mb", 32'(bus_if.makeBreak), 1);
    chk("t5_fe2", 32'(nfe - fe0), 1);
    mark();
    send_frame(8'h2B, 0, 0, 1);
    chk("t6_code", 32'(bus_if.keyboard_code), 32'h2B);
    chk("t6_cv", 32'(ncv - cv0), 1);
    chk("t6_fe", 32'(nfe - fe0), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Front end of the keyboard input path. Receives raw PS/2 clock and data lines from the keyboard connector.
- Deserializes 11-bit PS/2 device-to-host frames.
- Resolves the F0 (break) and E0 (extended) prefix bytes.
- Presents one resolved scan code per key event as keyboard_code plus makeBreak (1 = press, 0 = release) to the key-to-note converter directly downstream.

Parameters:
- FILTER_LEN, 8: consecutive identical samples of synchronized ps2_clk required before the filtered clock changes level.
- TIMEOUT_CYCLES, 50000: system clocks without a filtered ps2_clk falling edge, while mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the connector; asynchronous.
- ps2_dat  input  1  raw PS/2 data from the connector; asynchronous.
- keyboard_code  output  8  last resolved scan code, prefixes stripped; held between events.
- makeBreak  output  1  1 = make (press), 0 = break (release) for keyboard_code.
- extended  output  1  1 if the code was preceded by E0.
- code_valid  output  1  one-cycle pulse when keyboard_code/makeBreak/extended update.
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.

Behaviour:
- Reset (synchronous, active-high) forces:
  - keyboard_code=8'h00, makeBreak=0, extended=0, code_valid=0, frame_err=0.
  - Frame FSM to IDLE; shift register, bit counter and timeout counter to 0.
  - break_pending=0, ext_pending=0.
  - Synchronizer and filter flops to 1 (bus idle).
  - Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - The filtered clock changes level only after FILTER_LEN consecutive equal samples.
  - A falling edge (fe) is a one-cycle strobe when the filtered clock goes 1->0.
  - Data is sampled from synchronized ps2_dat in the fe cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on fe with data=0 (start bit) go to DATA, clear bit count. On fe with data=1, stay in IDLE with no error.
  - DATA: on each fe shift data in, LSB first. After the 8th bit go to PARITY.
  - PARITY: on fe capture the parity bit and go to STOP. Parity is odd: 8 data bits plus the parity bit contain an odd number of ones.
  - STOP: on fe go to IDLE. If stop=1 and parity is correct, the byte is accepted. Otherwise frame_err pulses the next cycle, the byte is dropped, and both pending flags are cleared.
  - Timeout: in DATA, PARITY or STOP, the counter increments every clock and clears on fe. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear both pending flags. The timeout counter is held at 0 in IDLE.
- Code layer, on each accepted byte:
  - 8'hF0: set break_pending; no code_valid.
  - 8'hE0: set ext_pending; no code_valid.
  - Any other byte B: on the next cycle keyboard_code=B, makeBreak=~break_pending, extended=ext_pending, code_valid=1 for exactly one cycle. Then clear both pending flags.
  - Repeated prefixes (F0 F0, E0 E0) leave the flag set; no error.
- Latency: outputs update and code_valid pulses exactly 1 clock after the fe cycle that samples the stop bit.
- Outputs other than the pulses hold their value until the next code_valid.
- Typematic repeats (same make code resent) each produce a fresh code_valid with makeBreak=1.
- Host-to-device transmission is not supported; both PS/2 lines are input-only.

Test Plan:
- Reset asserted for 3 cycles mid-frame (after 4 data bits), then full frame 1C -> no frame_err. After the 1C frame: code_valid once, keyboard_code=8'h1C, makeBreak=1, extended=0.
- Frames F0 then 1C -> no code_valid after F0. After 1C: code_valid once, keyboard_code=8'h1C, makeBreak=0.
- Frames E0, F0, 5A -> single code_valid: keyboard_code=8'h5A, makeBreak=0, extended=1. Then frame 29 -> keyboard_code=8'h29, makeBreak=1, extended=0.
- Frame 23 with parity bit inverted -> frame_err pulses once, no code_valid, keyboard_code unchanged. Then F0 followed by a stop=0 frame, then 24 -> 24 reported with makeBreak=1 (pending break cleared by the error).
- Start bit plus 3 data bits, then bus idle for TIMEOUT_CYCLES+10 -> exactly one frame_err, FSM in IDLE. Next clean frame 16 -> keyboard_code=8'h16, makeBreak=1.
- Glitch pulses on ps2_clk shorter than FILTER_LEN-1 cycles in the middle of a frame 2B -> no extra bits sampled. keyboard_code=8'h2B, code_valid once, no frame_err.
